comparador_serial_ctrl: RTL and testbench

Sequential N-bit magnitude comparator controller. It loads two operands, feeds them MSB-first through a single 1-bit compare cell, and stops at the first differing bit. It produces registered mayor/menor/igual flags with a one-cycle done pulse. It sits between operand sources and any logic that needs A-vs-B ordering, trading latency for one shared 1-bit comparator.

---
 rtl/comparador_pkg.sv | 15 +
 rtl/comparador_bit.sv | 12 +
 rtl/comparador_serial_ctrl.sv | 96 +++++++++
 tb/tb_comparador_serial_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/comparador_pkg.sv
// Shared constants for the serial magnitude comparator: FSM encoding and result-flag slots.
package comparador_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int unsigned RES_IGUAL = 0;
  localparam int unsigned RES_MENOR = 1;
  localparam int unsigned RES_MAYOR = 2;
  localparam int unsigned RES_W     = 3;

  typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/comparador_bit.sv
// Combinational 1-bit compare cell; reusable by any MSB-first serial arithmetic block.
module comparador_bit (
  input  logic x,
  input  logic y,
  output logic eq,
  output logic gt
);

  assign eq = ~(x ^ y);
  assign gt = x & ~y;

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Serial N-bit unsigned magnitude comparator: shifts operands MSB-first through one
// 1-bit cell and stops at the first differing bit.
module comparador_serial_ctrl
  import comparador_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         mayor,
  output logic         menor,
  output logic         igual
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    sa_q, sa_d;
  logic [N-1:0]    sb_q, sb_d;
  logic [IdxW-1:0] idx_q, idx_d;
  res_t            res_q, res_d;
  logic            bit_eq, bit_gt;

  comparador_bit u_bit (
    .x  (sa_q[N-1]),
    .y  (sb_q[N-1]),
    .eq (bit_eq),
    .gt (bit_gt)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COMPARE;
          sa_d    = a;
          sb_d    = b;
          idx_d   = '0;
        end
      end
      ST_COMPARE: begin
        if (!bit_eq) begin
          res_d            = '0;
          res_d[RES_MAYOR] = bit_gt;
          res_d[RES_MENOR] = ~bit_gt;
          state_d          = ST_DONE;
        end else if (idx_q == IdxLast) begin
          res_d            = '0;
          res_d[RES_IGUAL] = 1'b1;
          state_d          = ST_DONE;
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          idx_d = idx_q + IdxW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset is synchronous; it also drops any comparison in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign mayor = res_q[RES_MAYOR];
  assign menor = res_q[RES_MENOR];
  assign igual = res_q[RES_IGUAL];

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Bench for comparador_serial_ctrl: N=8 and N=1 instances checked every cycle against a
// latency/ordering model, plus directed literal expectations.
module tb_comparador_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, mayor8, menor8, igual8;
  logic       busy1, done1, mayor1, menor1, igual1;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  comparador_serial_ctrl #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .mayor (mayor8),
    .menor (menor8),
    .igual (igual8)
  );

  comparador_serial_ctrl #(.N(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .mayor (mayor1),
    .menor (menor1),
    .igual (igual1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: rem = cycles of busy still to come; done in the last one; flags {mayor,menor,igual}.
  typedef struct {
    int         rem;
    logic [2:0] flags;
    logic [2:0] pend;
  } model_t;

  function automatic model_t step(model_t m, logic rn, logic st, logic [31:0] a,
                                  logic [31:0] b, int n);
    int  j;
    bit  found;
    if (!rn) begin
      m.rem   = 0;
      m.flags = 3'b000;
      return m;
    end
    if (m.rem > 0) begin
      m.rem--;
      if (m.rem == 1) m.flags = m.pend;
    end else if (st) begin
      found = 1'b0;
      j     = n;
      for (int k = n - 1; k >= 0; k--) begin
        if (!found && a[k] != b[k]) begin
          found = 1'b1;
          j     = n - 1 - k;
        end
      end
      m.rem  = found ? j + 2 : n + 1;
      m.pend = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
    end
    return m;
  endfunction

  model_t m8 = '{rem: 0, flags: 3'b000, pend: 3'b000};
  model_t m1 = '{rem: 0, flags: 3'b000, pend: 3'b000};

  always @(posedge clk) begin
    m8 = step(m8, rst_n, start8, 32'(a8), 32'(b8), 8);
    m1 = step(m1, rst_n, start1, 32'(a1), 32'(b1), 1);
  end

  always @(negedge clk) begin
    cyc++;
    if (check_en) begin
      chk("m8_busy", 32'(busy8), 32'(m8.rem > 0));
      chk("m8_done", 32'(done8), 32'(m8.rem == 1));
      chk("m8_flags", 32'({mayor8, menor8, igual8}), 32'(m8.flags));
      chk("m1_busy", 32'(busy1), 32'(m1.rem > 0));
      chk("m1_done", 32'(done1), 32'(m1.rem == 1));
      chk("m1_flags", 32'({mayor1, menor1, igual1}), 32'(m1.flags));
    end
  end

  // Starts a comparison on the N=8 instance; returns cycles from accept edge to done.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int pulse_at,
                      output int lat);
    @(negedge clk);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h00;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    if (!done8) chk("run8_timeout", 32'(done8), 32'd1);
  endtask

  task automatic run1(input logic av, input logic bv, output int lat);
    @(negedge clk);
    start1 = 1'b1;
    a1     = av;
    b1     = bv;
    @(negedge clk);
    start1 = 1'b0;
    lat    = 1;
    while (!done1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done1) chk("run1_timeout", 32'(done1), 32'd1);
  endtask

  initial begin
    int lat;
    int dcnt;
    int t_done[$];
    rst_n  = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    a8     = '0;
    b8     = '0;
    a1     = '0;
    b1     = '0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_flags", 32'({mayor8, menor8, igual8}), 32'd0);
    rst_n = 1'b1;

    run8(8'hA5, 8'h25, 0, lat);
    chk("msb_lat", 32'(lat), 32'd2);
    chk("msb_flags", 32'({mayor8, menor8, igual8}), 32'b100);

    run8(8'h10, 8'h11, 0, lat);
    chk("lsb_lat", 32'(lat), 32'd9);
    chk("lsb_flags", 32'({mayor8, menor8, igual8}), 32'b010);

    run8(8'h3C, 8'h3C, 0, lat);
    chk("eq_lat", 32'(lat), 32'd9);
    chk("eq_flags", 32'({mayor8, menor8, igual8}), 32'b001);
    @(negedge clk);
    chk("eq_busy_fall", 32'(busy8), 32'd0);

    run8(8'h10, 8'h11, 3, lat);
    chk("ign_lat", 32'(lat), 32'd9);
    chk("ign_flags", 32'({mayor8, menor8, igual8}), 32'b010);
    repeat (5) @(negedge clk);
    chk("ign_hold", 32'({mayor8, menor8, igual8}), 32'b010);
    chk("ign_idle", 32'(busy8), 32'd0);

    // Reset in the middle of a comparison that would take 8+ cycles.
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'h02;
    b8     = 8'h03;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_outs", 32'({busy8, done8, mayor8, menor8, igual8}), 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);
    run8(8'hA5, 8'h25, 0, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_flags", 32'({mayor8, menor8, igual8}), 32'b100);

    run1(1'b1, 1'b0, lat);
    chk("n1_gt_lat", 32'(lat), 32'd2);
    chk("n1_gt_flags", 32'({mayor1, menor1, igual1}), 32'b100);
    run1(1'b1, 1'b1, lat);
    chk("n1_eq_lat", 32'(lat), 32'd2);
    chk("n1_eq_flags", 32'({mayor1, menor1, igual1}), 32'b001);

    // Held start: done pulses must be N+2 = 3 cycles apart.
    @(negedge clk);
    start1 = 1'b1;
    a1     = 1'b0;
    b1     = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done1) t_done.push_back(cyc);
    end
    start1 = 1'b0;
    chk("n1_pulses", 32'(t_done.size() >= 3), 32'd1);
    for (int i = 1; i < t_done.size(); i++)
      chk("n1_spacing", 32'(t_done[i] - t_done[i-1]), 32'd3);
    chk("n1_bb_flags", 32'({mayor1, menor1, igual1}), 32'b010);

    repeat (5) @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
